reg_file: RTL



---
 rtl/reg_file.sv | 61 ++++++
 1 files changed

// File: rtl/reg_file.sv
// reg_file: 32-entry general-purpose register file for the single-cycle MIPS datapath.
// It has two combinational read ports and one write port that writes on the rising edge.
// Register $0 always reads as zero, and register 29 ($sp) resets to SP_RESET.
// There is no write-first bypass. Read data feeds the ALU, and the ALU result returns as
// write data in the same cycle, so a bypass would close a combinational loop.
// Optional feature: define REG_FILE_DEBUG_PORT_EN to add a third read port
// (dbg_addr/dbg_data) for the board-level register display.
`timescale 1ns/1ps

module reg_file #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 5,
  parameter logic [DATA_W-1:0]  SP_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data
`ifdef REG_FILE_DEBUG_PORT_EN
  ,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`endif
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int SP_IDX   = 29;

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic w_wr_en;

  // A write needs the enable and a non-zero target. Checking reg_write first
  // means an undefined address cannot touch storage while writes are off.
  assign w_wr_en = reg_write && (write_reg != '0);

  // Storage array: async reset loads the power-on contents, otherwise one write per edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_regs         <= '{default: '0};
      r_regs[SP_IDX] <= SP_RESET;
    end else if (w_wr_en) begin
      r_regs[write_reg] <= write_data;
    end
  end

  // Read ports: address 0 is forced to zero, whatever the storage holds
  assign read_data1 = (read_reg1 == '0) ? '0 : r_regs[read_reg1];
  assign read_data2 = (read_reg2 == '0) ? '0 : r_regs[read_reg2];

`ifdef REG_FILE_DEBUG_PORT_EN
  // Debug read port: follows the same rules as the datapath ports and has no side effects
  assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
`endif

endmodule
